// File: rtl/multi_widget_engine_pkg.sv
// Shared constants and payload types for the multi-widget animation engine.
package multi_widget_engine_pkg;

    localparam int unsigned COORD_W_DEF  = 11;
    localparam int unsigned H_ACTIVE_DEF = 640;
    localparam int unsigned V_ACTIVE_DEF = 480;

    localparam int unsigned COLOR_W = 4;
    localparam int unsigned RGB_W   = 3 * COLOR_W;
    localparam int unsigned SIZE_W  = 9;
    localparam int unsigned STEP_W  = 5;
    localparam int unsigned ID_W    = 3;

    // Bit offsets of each channel inside a packed {r,g,b} colour word
    localparam int unsigned RED_LO   = 2 * COLOR_W;
    localparam int unsigned GREEN_LO = COLOR_W;
    localparam int unsigned BLUE_LO  = 0;

    // Priority-resolved result for one pixel
    typedef struct packed {
        logic              yes;
        logic [ID_W-1:0]   id;
        logic [RGB_W-1:0]  rgb;
        logic              overlap;
    } pix_res_t;

endpackage

// File: rtl/multi_widget_engine_if.sv
// Pixel query bus: coordinate from the VGA driver, colour/status back to the client.
interface multi_widget_engine_if #(
    parameter int unsigned COORD_W = 11
);
    logic [COORD_W-1:0] X;
    logic [COORD_W-1:0] Y;
    logic               yes;
    logic [3:0]         red;
    logic [3:0]         green;
    logic [3:0]         blue;
    logic [2:0]         widgetId;
    logic               overlap;

    modport master (
        output X, Y,
        input  yes, red, green, blue, widgetId, overlap
    );

    modport slave (
        input  X, Y,
        output yes, red, green, blue, widgetId, overlap
    );
endinterface

// File: rtl/multi_widget_engine_widget_motion.sv
// One bouncing rectangle: position/direction state, edge bounce and pixel hit test.
module widget_motion
    import multi_widget_engine_pkg::*;
#(
    parameter int unsigned COORD_W  = COORD_W_DEF,
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               step,
    input  logic [COORD_W-1:0] first_x,
    input  logic [COORD_W-1:0] first_y,
    input  logic [SIZE_W-1:0]  x_size,
    input  logic [SIZE_W-1:0]  y_size,
    input  logic [STEP_W-1:0]  del_x,
    input  logic [STEP_W-1:0]  del_y,
    input  logic [COORD_W-1:0] px,
    input  logic [COORD_W-1:0] py,
    output logic               hit_c,
    output logic               edge_hit
);

    localparam int unsigned W1 = COORD_W + 1;
    localparam logic [W1-1:0] LIM_X = W1'(H_ACTIVE);
    localparam logic [W1-1:0] LIM_Y = W1'(V_ACTIVE);

    typedef struct packed {
        logic [COORD_W-1:0] pos;
        logic               dir;
        logic               bounce;
    } axis_t;

    logic [COORD_W-1:0] pos_x, pos_y;
    logic               dir_x, dir_y;
    axis_t              nx_c, ny_c;

    // Next position/direction for one axis; all arithmetic one bit wider so nothing wraps
    function automatic axis_t axis_next(
        input logic [COORD_W-1:0] pos,
        input logic               dir,
        input logic [SIZE_W-1:0]  size,
        input logic [STEP_W-1:0]  del,
        input logic [W1-1:0]      limit
    );
        axis_t         r;
        logic [W1-1:0] pos_w;
        logic [W1-1:0] size_w;
        logic [W1-1:0] del_w;
        pos_w    = W1'(pos);
        size_w   = W1'(size);
        del_w    = W1'(del);
        r.pos    = pos;
        r.dir    = dir;
        r.bounce = 1'b0;
        if (size_w >= limit) begin
            // Rectangle wider than the screen: pin to the origin
            r.pos = '0;
        end else if (del_w != '0) begin
            if (dir) begin
                if (pos_w + del_w + size_w >= limit) begin
                    r.pos    = COORD_W'(limit - size_w);
                    r.dir    = 1'b0;
                    r.bounce = 1'b1;
                end else begin
                    r.pos = COORD_W'(pos_w + del_w);
                end
            end else begin
                if (pos_w <= del_w) begin
                    r.pos    = '0;
                    r.dir    = 1'b1;
                    r.bounce = 1'b1;
                end else begin
                    r.pos = COORD_W'(pos_w - del_w);
                end
            end
        end
        return r;
    endfunction

    // Candidate state for both axes from the live size/step inputs
    always_comb begin
        nx_c = axis_next(pos_x, dir_x, x_size, del_x, LIM_X);
        ny_c = axis_next(pos_y, dir_y, y_size, del_y, LIM_Y);
    end

    // Position/direction registers; edge pulse lasts only the cycle after a strobe
    always_ff @(posedge clk) begin
        if (!reset) begin
            pos_x    <= first_x;
            pos_y    <= first_y;
            dir_x    <= 1'b1;
            dir_y    <= 1'b1;
            edge_hit <= 1'b0;
        end else begin
            edge_hit <= 1'b0;
            if (step) begin
                pos_x    <= nx_c.pos;
                pos_y    <= ny_c.pos;
                dir_x    <= nx_c.dir;
                dir_y    <= ny_c.dir;
                edge_hit <= nx_c.bounce | ny_c.bounce;
            end
        end
    end

    // Half-open rectangle containment against the pre-strobe position
    assign hit_c = (W1'(px) >= W1'(pos_x)) && (W1'(px) < W1'(pos_x) + W1'(x_size)) &&
                   (W1'(py) >= W1'(pos_y)) && (W1'(py) < W1'(pos_y) + W1'(y_size));

endmodule

// File: rtl/multi_widget_engine.sv
// Animates NUM_WIDGETS bouncing rectangles and returns a priority-resolved pixel colour.
module multi_widget_engine
    import multi_widget_engine_pkg::*;
#(
    parameter int unsigned NUM_WIDGETS = 4,
    parameter int unsigned H_ACTIVE    = H_ACTIVE_DEF,
    parameter int unsigned V_ACTIVE    = V_ACTIVE_DEF,
    parameter int unsigned COORD_W     = COORD_W_DEF
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          pause,
    input  logic [NUM_WIDGETS*COORD_W-1:0] firstX,
    input  logic [NUM_WIDGETS*COORD_W-1:0] firstY,
    input  logic [NUM_WIDGETS*SIZE_W-1:0]  xSize,
    input  logic [NUM_WIDGETS*SIZE_W-1:0]  ySize,
    input  logic [NUM_WIDGETS*STEP_W-1:0]  delX,
    input  logic [NUM_WIDGETS*STEP_W-1:0]  delY,
    input  logic [NUM_WIDGETS*RGB_W-1:0]   colorIn,
    multi_widget_engine_if.slave           pix,
    output logic                          collideFrame,
    output logic [NUM_WIDGETS-1:0]        edgeHit
);

    logic                   step_c;
    logic [NUM_WIDGETS-1:0] hit_c;
    pix_res_t               res_c;
    pix_res_t               res_q;

    assign step_c = enable & ~pause;

    // One motion/hit-test unit per widget
    for (genvar i = 0; i < NUM_WIDGETS; i++) begin : g_widget
        widget_motion #(
            .COORD_W  (COORD_W),
            .H_ACTIVE (H_ACTIVE),
            .V_ACTIVE (V_ACTIVE)
        ) u_motion (
            .clk      (clk),
            .reset    (reset),
            .step     (step_c),
            .first_x  (firstX[i*COORD_W +: COORD_W]),
            .first_y  (firstY[i*COORD_W +: COORD_W]),
            .x_size   (xSize[i*SIZE_W +: SIZE_W]),
            .y_size   (ySize[i*SIZE_W +: SIZE_W]),
            .del_x    (delX[i*STEP_W +: STEP_W]),
            .del_y    (delY[i*STEP_W +: STEP_W]),
            .px       (pix.X),
            .py       (pix.Y),
            .hit_c    (hit_c[i]),
            .edge_hit (edgeHit[i])
        );
    end

    // Lowest-index hit wins; any later hit marks an overlap
    always_comb begin
        res_c = '0;
        for (int i = 0; i < NUM_WIDGETS; i++) begin
            if (hit_c[i]) begin
                if (res_c.yes) begin
                    res_c.overlap = 1'b1;
                end else begin
                    res_c.yes = 1'b1;
                    res_c.id  = ID_W'(i);
                    res_c.rgb = colorIn[i*RGB_W +: RGB_W];
                end
            end
        end
    end

    // Pixel output register
    always_ff @(posedge clk) begin
        if (!reset) begin
            res_q <= '0;
        end else begin
            res_q <= res_c;
        end
    end

    // Sticky collision flag: cleared by an accepted strobe, frozen while paused
    always_ff @(posedge clk) begin
        if (!reset) begin
            collideFrame <= 1'b0;
        end else if (step_c) begin
            collideFrame <= 1'b0;
        end else if (!pause && res_q.overlap) begin
            collideFrame <= 1'b1;
        end
    end

    assign pix.yes      = res_q.yes;
    assign pix.widgetId = res_q.id;
    assign pix.red      = res_q.rgb[RED_LO +: COLOR_W];
    assign pix.green    = res_q.rgb[GREEN_LO +: COLOR_W];
    assign pix.blue     = res_q.rgb[BLUE_LO +: COLOR_W];
    assign pix.overlap  = res_q.overlap;

endmodule

// File: tb/tb_multi_widget_engine.sv
// Directed bench for multi_widget_engine: static pixel table plus motion/collision sequences.
module tb_multi_widget_engine;

    localparam int unsigned NW = 4;
    localparam int unsigned CW = 11;

    logic            clk;
    logic            reset;
    logic            enable;
    logic            pause;
    logic [NW*CW-1:0] firstX, firstY;
    logic [NW*9-1:0]  xSize, ySize;
    logic [NW*5-1:0]  delX, delY;
    logic [NW*12-1:0] colorIn;
    logic             collideFrame;
    logic [NW-1:0]    edgeHit;

    multi_widget_engine_if #(.COORD_W(CW)) pix ();

    multi_widget_engine #(
        .NUM_WIDGETS (NW),
        .H_ACTIVE    (640),
        .V_ACTIVE    (480),
        .COORD_W     (CW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .pause        (pause),
        .firstX       (firstX),
        .firstY       (firstY),
        .xSize        (xSize),
        .ySize        (ySize),
        .delX         (delX),
        .delY         (delY),
        .colorIn      (colorIn),
        .pix          (pix),
        .collideFrame (collideFrame),
        .edgeHit      (edgeHit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [10:0] x;
        logic [10:0] y;
        logic        yes;
        logic [2:0]  id;
        logic [11:0] rgb;
        logic        ov;
    } vec_t;

    vec_t vecs[11];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_pix(input string name, input logic yes, input logic [2:0] id,
                             input logic [11:0] rgb, input logic ov);
        check({name, ".yes"}, int'(pix.yes), int'(yes));
        check({name, ".id"}, int'(pix.widgetId), int'(id));
        check({name, ".rgb"}, int'({pix.red, pix.green, pix.blue}), int'(rgb));
        check({name, ".ov"}, int'(pix.overlap), int'(ov));
    endtask

    task automatic set_xy(input int x, input int y);
        pix.X = 11'(x);
        pix.Y = 11'(y);
    endtask

    initial begin
        // Widget layout: w0 (0,0) 20x20 F00, w1 (300,300) 10x10 0A5,
        // w2 (90,90) 20x20 0F0, w3 (500,400) 10x10 00F; no motion initially
        reset   = 1'b0;
        enable  = 1'b0;
        pause   = 1'b0;
        firstX  = {11'd500, 11'd90, 11'd300, 11'd0};
        firstY  = {11'd400, 11'd90, 11'd300, 11'd0};
        xSize   = {9'd10, 9'd20, 9'd10, 9'd20};
        ySize   = {9'd10, 9'd20, 9'd10, 9'd20};
        delX    = '0;
        delY    = '0;
        colorIn = {12'h00F, 12'h0F0, 12'h0A5, 12'hF00};
        set_xy(5, 5);

        vecs[0]  = '{11'd5,    11'd5,    1'b1, 3'd0, 12'hF00, 1'b0};
        vecs[1]  = '{11'd20,   11'd5,    1'b0, 3'd0, 12'h000, 1'b0};
        vecs[2]  = '{11'd19,   11'd19,   1'b1, 3'd0, 12'hF00, 1'b0};
        vecs[3]  = '{11'd0,    11'd20,   1'b0, 3'd0, 12'h000, 1'b0};
        vecs[4]  = '{11'd300,  11'd300,  1'b1, 3'd1, 12'h0A5, 1'b0};
        vecs[5]  = '{11'd309,  11'd309,  1'b1, 3'd1, 12'h0A5, 1'b0};
        vecs[6]  = '{11'd310,  11'd300,  1'b0, 3'd0, 12'h000, 1'b0};
        vecs[7]  = '{11'd95,   11'd95,   1'b1, 3'd2, 12'h0F0, 1'b0};
        vecs[8]  = '{11'd505,  11'd405,  1'b1, 3'd3, 12'h00F, 1'b0};
        vecs[9]  = '{11'd2047, 11'd2047, 1'b0, 3'd0, 12'h000, 1'b0};
        vecs[10] = '{11'd89,   11'd95,   1'b0, 3'd0, 12'h000, 1'b0};

        // Outputs stay zero while reset is held, even over a covered pixel
        repeat (2) tick();
        check_pix("reset", 1'b0, 3'd0, 12'h000, 1'b0);
        check("reset.collide", int'(collideFrame), 0);
        check("reset.edge", int'(edgeHit), 0);

        // Static hit table
        reset = 1'b1;
        for (int i = 0; i < 11; i++) begin
            set_xy(int'(vecs[i].x), int'(vecs[i].y));
            tick();
            check_pix($sformatf("vec%0d", i), vecs[i].yes, vecs[i].id, vecs[i].rgb, vecs[i].ov);
        end

        // One strobe moves w0 to (6,4)
        delX[4:0] = 5'd6;
        delY[4:0] = 5'd4;
        enable = 1'b1;
        tick();
        check("strobe.edge", int'(edgeHit), 0);
        enable = 1'b0;
        set_xy(5, 3);
        tick();
        check("strobe.miss", int'(pix.yes), 0);
        set_xy(6, 4);
        tick();
        check_pix("strobe.hit", 1'b1, 3'd0, 12'hF00, 1'b0);

        // Grow w0 live so it overlaps w2 at (100,100)
        xSize[8:0] = 9'd200;
        ySize[8:0] = 9'd200;
        set_xy(100, 100);
        tick();
        check_pix("overlap", 1'b1, 3'd0, 12'hF00, 1'b1);
        check("overlap.collide_pre", int'(collideFrame), 0);
        tick();
        check("overlap.collide", int'(collideFrame), 1);

        // Paused strobes are ignored
        pause  = 1'b1;
        enable = 1'b1;
        set_xy(5, 4);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("pause.edge%0d", i), int'(edgeHit), 0);
        end
        enable = 1'b0;
        check("pause.miss", int'(pix.yes), 0);
        check("pause.collide", int'(collideFrame), 1);
        set_xy(6, 4);
        tick();
        check("pause.hit", int'(pix.yes), 1);
        pause = 1'b0;

        // Strobe clear beats an overlap set in the same cycle
        set_xy(100, 100);
        tick();
        enable = 1'b1;
        tick();
        check("clear_wins", int'(collideFrame), 0);
        enable = 1'b0;
        tick();
        check("reset_after_clear", int'(collideFrame), 1);

        // Right-edge bounce: w0 restarted at (615,0), 20x20, step 6
        reset = 1'b0;
        firstX[10:0] = 11'd615;
        firstY[10:0] = 11'd0;
        xSize[8:0]   = 9'd20;
        ySize[8:0]   = 9'd20;
        delY[4:0]    = 5'd0;
        set_xy(615, 0);
        tick();
        check_pix("reset2", 1'b0, 3'd0, 12'h000, 1'b0);
        check("reset2.collide", int'(collideFrame), 0);
        reset = 1'b1;
        tick();
        check("edge.start", int'(pix.yes), 1);
        enable = 1'b1;
        tick();
        check("edge.pulse", int'(edgeHit), 1);
        enable = 1'b0;
        set_xy(620, 0);
        tick();
        check("edge.pulse_end", int'(edgeHit), 0);
        check("edge.at620", int'(pix.yes), 1);
        set_xy(619, 0);
        tick();
        check("edge.miss619", int'(pix.yes), 0);
        enable = 1'b1;
        tick();
        check("edge.back_noedge", int'(edgeHit), 0);
        enable = 1'b0;
        set_xy(614, 0);
        tick();
        check("edge.at614", int'(pix.yes), 1);
        set_xy(613, 0);
        tick();
        check("edge.miss613", int'(pix.yes), 0);

        // Reset right after a strobe restores the start position
        enable = 1'b1;
        tick();
        enable = 1'b0;
        reset  = 1'b0;
        set_xy(608, 0);
        tick();
        check_pix("midreset", 1'b0, 3'd0, 12'h000, 1'b0);
        check("midreset.edge", int'(edgeHit), 0);
        check("midreset.collide", int'(collideFrame), 0);
        reset = 1'b1;
        set_xy(615, 0);
        tick();
        check("midreset.at615", int'(pix.yes), 1);
        set_xy(608, 0);
        tick();
        check("midreset.miss608", int'(pix.yes), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/multi_widget_engine.md
Name: multi_widget_engine

Overview:
- Parameterised successor to the single bouncing widget: animates NUM_WIDGETS independent rectangles, each with its own size, step, colour and start point.
- Each rectangle bounces off the edges of the active display area.
- For each pixel coordinate from the VGA driver, returns a registered, priority-resolved colour plus overlap/collision status.
- Sits between the VGA low-level driver/clock divider and the VGA client; the client mixes its output over the background.

Parameters:
- NUM_WIDGETS, 4, number of rectangles (1..8)
- H_ACTIVE, 640, active width in pixels
- V_ACTIVE, 480, active height in lines
- COORD_W, 11, width of X/Y and position registers

Ports:
- clk  in  1  system clock (100 MHz)
- reset  in  1  synchronous, active-low reset
- enable  in  1  single-cycle motion strobe (10 Hz divider output)
- pause  in  1  1 = ignore enable; positions frozen
- X  in  COORD_W  current pixel X
- Y  in  COORD_W  current pixel Y
- firstX  in  NUM_WIDGETS*COORD_W  start X per widget (slice i = widget i)
- firstY  in  NUM_WIDGETS*COORD_W  start Y per widget
- xSize  in  NUM_WIDGETS*9  width per widget
- ySize  in  NUM_WIDGETS*9  height per widget
- delX  in  NUM_WIDGETS*5  X step per strobe
- delY  in  NUM_WIDGETS*5  Y step per strobe
- colorIn  in  NUM_WIDGETS*12  {r,g,b} 4 bits each per widget
- yes  out  1  some widget covers pixel
- red  out  4  winning widget red
- green  out  4  winning widget green
- blue  out  4  winning widget blue
- widgetId  out  3  index of winning widget
- overlap  out  1  two or more widgets cover pixel
- collideFrame  out  1  sticky: overlap seen since last accepted strobe
- edgeHit  out  NUM_WIDGETS  one-cycle pulse per widget that bounced this strobe

Behaviour:
- Reset: sampled on clk rising edge while reset==0.
  - posX[i]/posY[i] load firstX/firstY slices; dirX[i]=dirY[i]=1 (increasing).
  - All outputs 0; collideFrame=0.
- firstX/firstY are used only at reset. Size, step and colour inputs are live and may change at any time.
- Motion: applied on a cycle with enable==1, pause==0 and reset==1; all widgets update in the same cycle. X axis, per widget (Y identical, using V_ACTIVE/ySize/delY):
  - dirX=1:
    - If posX+delX+xSize >= H_ACTIVE: posX<=H_ACTIVE-xSize, dirX<=0, edgeHit[i] pulses.
    - Else posX<=posX+delX.
  - dirX=0:
    - If posX <= delX: posX<=0, dirX<=1, edgeHit[i] pulses.
    - Else posX<=posX-delX.
  - Sums computed at COORD_W+1 bits; no wrap.
  - delX==0: position and direction unchanged, no pulse.
  - xSize >= H_ACTIVE: posX forced 0, dir unchanged, no pulse.
  - A simultaneous X and Y bounce gives a single edgeHit pulse.
- edgeHit: high exactly the cycle after the accepted strobe, otherwise 0.
- Hit test, per widget, combinational:
  - posX<=X<posX+xSize AND posY<=Y<posY+ySize, compared at COORD_W+1 bits.
  - Coordinates outside the active area compare like any other value.
- Priority: lowest index wins.
- Output register: yes/red/green/blue/widgetId/overlap are registered with 1-cycle latency from X/Y.
  - No hit: yes=0, rgb=0, widgetId=0, overlap=0.
- Position timing: the hit test uses positions as they were before the strobe; the new position is visible from the cycle after the strobe.
- collideFrame:
  - Set on any cycle whose registered overlap==1.
  - Cleared on an accepted strobe; the clear wins over a set in the same cycle.
  - Held while pause==1.
- Reset mid-frame: positions reload firstX/firstY; no partial update survives.

Decomposition:
- Shared package vga_pkg: H_ACTIVE/V_ACTIVE defaults, COORD_W, colour width 4, slice-index helper constants.
- One sub-module widget_motion: position/direction registers, edge logic and hit test for a single widget. Instantiated NUM_WIDGETS times via generate.
- The top handles priority, the output register and collideFrame.

Test Plan:
- Reset with widget0 firstX=0, firstY=0, size 20x20 -> at X=5,Y=5 one cycle later: yes=1, widgetId=0, rgb=colorIn0. At X=20,Y=5: yes=0.
- Widget0 delX=6, delY=4, one strobe -> posX=6, posY=4. Pixel (5,3) misses; (6,4) hits.
- Widget0 posX=615, xSize=20, delX=6, dirX=1, strobe -> posX=620, dirX=0, edgeHit[0]=1 for one cycle. Next strobe -> posX=614.
- Widgets 0 and 2 both cover (100,100), colours F00 and 0F0 -> red=F, green=0, widgetId=0, overlap=1, collideFrame=1 until next strobe.
- pause=1 with enable pulses -> positions unchanged, edgeHit=0, collideFrame held.
- Reset asserted one cycle after a strobe -> positions back to firstX/firstY, all outputs 0 next cycle.
